// File: rtl/sync_pulse_arbiter.sv
// Round-robin scheduler sharing one SyncPulse channel among NUM_REQ requesters.
// Each transfer is a single-cycle din pulse with a requester ID sideband. An
// optional returned ack (already in clk_src) plus a fixed gap keep pulses far
// enough apart for the slower destination domain.
module sync_pulse_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned ID_W        = $clog2(NUM_REQ),
   parameter int unsigned GAP_CYCLES  = 4,
   parameter bit          USE_ACK     = 1'b1,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic               clk_src,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               din,
   output logic [ID_W-1:0]    din_id,
   input  logic               ack_in,
   output logic               busy,
   output logic               timeout_err,
   output logic               stray_ack
);

   localparam int unsigned TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0]   ACK_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0]   GAP_LAST = TW'(GAP_CYCLES - 1);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitAck,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] win_q, win_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            stray_q, stray_d;

   logic [ID_W-1:0] pick_idx;
   logic [ID_W-1:0] cand;
   logic [31:0]     base;
   logic [TW-1:0]   timer_inc;
   logic [ID_W-1:0] next_ptr;

   // Round-robin pick: first set req bit searching upward from rr_ptr, with wrap.
   always_comb begin
      pick_idx = '0;
      cand     = '0;
      base     = 32'(rr_ptr_q);
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         // Iterate downward so the lowest offset from rr_ptr is written last and wins.
         cand = ID_W'((base + i - 1) % NUM_REQ);
         if (req[cand]) begin
            pick_idx = cand;
         end
      end
   end

   // Saturating timer increment and pointer advance past the current winner.
   always_comb begin
      timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);
      next_ptr  = (win_q == LAST_ID) ? '0 : win_q + ID_W'(1);
   end

   // Next-state and output decode for the transfer sequencer.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      timer_d     = timer_q;
      grant       = '0;
      din         = 1'b0;
      timeout_err = 1'b0;
      busy        = (state_q != StIdle);
      // An ack outside WAIT_ACK never steers the FSM; it is only flagged.
      stray_d     = ack_in && (state_q != StWaitAck);

      case (state_q)
         StIdle: begin
            if (|req) begin
               win_d   = pick_idx;
               state_d = StIssue;
            end
         end
         StIssue: begin
            din      = 1'b1;
            grant    = NUM_REQ'(1) << win_q;
            rr_ptr_d = next_ptr;
            timer_d  = '0;
            state_d  = USE_ACK ? StWaitAck : StGap;
         end
         StWaitAck: begin
            timer_d = timer_inc;
            if (ack_in) begin
               timer_d = '0;
               state_d = StGap;
            end else if (timer_q == ACK_LAST) begin
               // Flagged in the last allowed wait cycle; ack in that cycle wins.
               timeout_err = 1'b1;
               timer_d     = '0;
               state_d     = StGap;
            end
         end
         StGap: begin
            timer_d = timer_inc;
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset drops pending acks.
   always_ff @(posedge clk_src) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         win_q    <= '0;
         timer_q  <= '0;
         stray_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         timer_q  <= timer_d;
         stray_q  <= stray_d;
      end
   end

   assign din_id    = win_q;
   assign stray_ack = stray_q;

endmodule
